sync_fifo_prog: RTL and testbench
=================================

Name: sync_fifo_prog

Overview:
Single-clock, parametrised FIFO that generalises the team's dual-clock FIFO for same-domain buffering. Adds the following features:
- selectable first-word-fall-through (FWFT) or registered-read mode;
- occupancy count;
- programmable almost-full and almost-empty thresholds;
- sticky overflow and underflow error flags.

It sits between producer and consumer pipeline stages that share one clock.

Parameters:
DATA_WIDTH, 8, width of wdata/rdata in bits
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH entries
FWFT, 0, 0 = registered read (data one cycle after rd_en); 1 = head word presented combinationally
AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1, and AE_LEVEL < AF_LEVEL

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous active-high reset
wr_en  input  1  write request
wdata  input  DATA_WIDTH  write data
rd_en  input  1  read/pop request
clr_err  input  1  synchronous clear of the overflow/underflow flags
rdata  output  DATA_WIDTH  read data
rvalid  output  1  rdata holds a freshly popped (FWFT=0) or head (FWFT=1) word
wfull  output  1  count == DEPTH
rempty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  ADDR_WIDTH+1  occupancy, 0..DEPTH
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty

Behaviour:
- Reset (rst=1 at a rising edge) sets:
  - write/read pointers = 0, count = 0;
  - rempty = 1, wfull = 0, almost_empty = 1, almost_full = 0;
  - rvalid = 0, rdata = 0 (FWFT=0), overflow = 0, underflow = 0.
  - Memory contents are not reset.
- Reset dominates: wr_en, rd_en and clr_err are ignored in a reset cycle. Reset mid-stream discards all stored words. No reads return pre-reset data afterwards.
- Pointers are ADDR_WIDTH+1-bit binary. The low ADDR_WIDTH bits index memory, and the MSB distinguishes full from empty. Pointers wrap modulo 2*DEPTH with no special handling.
- A write is accepted iff wr_en && !wfull: mem[wptr] <= wdata, wptr+1.
- A read is accepted iff rd_en && !rempty: rptr+1.
- Full/empty are evaluated on current state only:
  - A write while full is rejected even if rd_en is high the same cycle.
  - A read while empty is rejected even if wr_en is high the same cycle.
- Count update per edge:
  - +1 if only the write is accepted;
  - -1 if only the read is accepted;
  - unchanged if both or neither are accepted.
  - count never leaves 0..DEPTH.
- wfull, rempty, almost_full and almost_empty are combinational decodes of registered count. They change in the cycle after the causing edge.
- FWFT=0:
  - On an accepted read, rdata <= mem[rptr] at that edge, and rvalid = 1 for exactly the following cycle.
  - Otherwise rvalid = 0 and rdata holds its last value.
  - Read latency is 1 cycle.
- FWFT=1:
  - rdata = mem[rptr] combinationally, and rvalid = !rempty.
  - rd_en pops the head; the next word appears the cycle after the pop.
  - A word written at edge N is visible on rdata after edge N (write-to-read latency 1 edge).
- overflow is set at an edge where wr_en && wfull. underflow is set at an edge where rd_en && rempty.
- Both flags hold until clr_err or rst. If clr_err and a new error occur in the same cycle, the flag is set (set wins).
- Rejected operations never alter pointers, count or memory.

Test Plan:
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=4, AF_LEVEL=12, AE_LEVEL=2.
- Fill, FWFT=0: after reset, write 0x01..0x10 on 16 consecutive edges -> count=16, wfull=1, almost_full from count=12; 17th write 0xAA -> rejected, overflow=1, count stays 16.
- Drain, FWFT=0: read 16 times -> rdata 0x01..0x10 in order, each one cycle after rd_en with rvalid pulses; rempty=1 after the last; extra rd_en -> underflow=1, rdata stays 0x10.
- Simultaneous: with count=5, assert wr_en and rd_en for 20 cycles -> count stays 5, data order preserved, and pointers wrap past 16 with no corruption.
- FWFT=1: write 0x3C into an empty FIFO -> next cycle rvalid=1, rdata=0x3C before any rd_en; one rd_en -> rempty=1, rvalid=0.
- Full plus read: at count=16, wr_en and rd_en together -> write rejected (overflow=1), read accepted, count=15. clr_err -> overflow=0.
- Reset mid-operation: at count=9, with wr_en high, pulse rst for one edge -> count=0, rempty=1, all flags 0, and the write in the reset cycle is ignored.

Source files
------------

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with selectable first-word-fall-through or registered read,
// occupancy count, programmable almost-full/almost-empty thresholds and
// sticky overflow/underflow flags.
module sync_fifo_prog #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  wfull,
    output logic                  rempty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_CNT   = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0] ONE      = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Pointers carry one extra wrap bit; the low bits index memory.
    logic [ADDR_WIDTH:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;
    logic                wr_acc;
    logic                rd_acc;

    // Status flags decode the registered count only, so they lag the causing edge by one cycle.
    assign wfull        = (count_q == FULL_CNT);
    assign rempty       = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // Acceptance looks at current state only: a same-cycle read never makes room for a write.
    assign wr_acc = wr_en && !wfull;
    assign rd_acc = rd_en && !rempty;

    // Next-state for pointers, occupancy and sticky error flags (a new error beats clr_err).
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_acc) wptr_d = wptr_q + ONE;
        if (rd_acc) rptr_d = rptr_q + ONE;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
        ovf_d = (ovf_q && !clr_err) || (wr_en && wfull);
        udf_d = (udf_q && !clr_err) || (rd_en && rempty);
    end

    // Control state register; reset overrides every request in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage array, not reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem_q[wptr_q[ADDR_WIDTH-1:0]] <= wdata;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented straight from memory whenever the FIFO holds data.
            assign rdata  = mem_q[rptr_q[ADDR_WIDTH-1:0]];
            assign rvalid = !rempty;
        end else begin : g_regrd
            logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
            logic                  rvalid_q, rvalid_d;

            // Popped word is captured at the accepting edge; rdata holds otherwise.
            always_comb begin
                rdata_d  = rdata_q;
                rvalid_d = rd_acc;
                if (rd_acc) rdata_d = mem_q[rptr_q[ADDR_WIDTH-1:0]];
            end

            // Read-data register with a one-cycle valid pulse per accepted pop.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rdata_q  <= rdata_d;
                    rvalid_q <= rvalid_d;
                end
            end

            assign rdata  = rdata_q;
            assign rvalid = rvalid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: one registered-read and one FWFT instance share
// the stimulus and are compared against a queue-based reference model.
module tb_sync_fifo_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;

    logic [7:0] rdata0, rdata1;
    logic       rvalid0, rvalid1, wfull0, wfull1, rempty0, rempty1;
    logic       af0, af1, ae0, ae1, ovf0, ovf1, udf0, udf1;
    logic [4:0] count0, count1;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    logic [7:0] m_rdata = 8'h00;
    logic       m_rvalid = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0), .AF_LEVEL(12), .AE_LEVEL(2)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en), .clr_err(clr_err),
        .rdata(rdata0), .rvalid(rvalid0), .wfull(wfull0), .rempty(rempty0),
        .almost_full(af0), .almost_empty(ae0), .count(count0),
        .overflow(ovf0), .underflow(udf0));

    sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1), .AF_LEVEL(12), .AE_LEVEL(2)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en), .clr_err(clr_err),
        .rdata(rdata1), .rvalid(rvalid1), .wfull(wfull1), .rempty(rempty1),
        .almost_full(af1), .almost_empty(ae1), .count(count1),
        .overflow(ovf1), .underflow(udf1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count0",   32'(count0),  32'(n));
        chk("wfull0",   32'(wfull0),  32'(n == 16));
        chk("rempty0",  32'(rempty0), 32'(n == 0));
        chk("afull0",   32'(af0),     32'(n >= 12));
        chk("aempty0",  32'(ae0),     32'(n <= 2));
        chk("ovf0",     32'(ovf0),    32'(m_ovf));
        chk("udf0",     32'(udf0),    32'(m_udf));
        chk("rvalid0",  32'(rvalid0), 32'(m_rvalid));
        chk("rdata0",   32'(rdata0),  32'(m_rdata));
        chk("count1",   32'(count1),  32'(n));
        chk("wfull1",   32'(wfull1),  32'(n == 16));
        chk("rempty1",  32'(rempty1), 32'(n == 0));
        chk("afull1",   32'(af1),     32'(n >= 12));
        chk("aempty1",  32'(ae1),     32'(n <= 2));
        chk("ovf1",     32'(ovf1),    32'(m_ovf));
        chk("udf1",     32'(udf1),    32'(m_udf));
        chk("rvalid1",  32'(rvalid1), 32'(n != 0));
        if (n != 0) chk("rdata1", 32'(rdata1), 32'(q[0]));
    endtask

    // Apply one cycle of inputs, advance the model by the FIFO rules, check after the edge.
    task automatic step(input logic w, input logic [7:0] d, input logic r,
                        input logic c, input logic rs);
        logic full, empty;
        wr_en = w; wdata = d; rd_en = r; clr_err = c; rst = rs;
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_ovf = 1'b0; m_udf = 1'b0; m_rdata = 8'h00; m_rvalid = 1'b0;
        end else begin
            full  = (q.size() == 16);
            empty = (q.size() == 0);
            m_ovf = (m_ovf && !c) || (w && full);
            m_udf = (m_udf && !c) || (r && empty);
            m_rvalid = r && !empty;
            if (r && !empty) m_rdata = q.pop_front();
            if (w && !full) q.push_back(d);
        end
        #1;
        check_all();
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic w, r, c, rs;
        int wp;

        // Reset state
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        chk("reset_rempty", 32'(rempty0), 32'd1);
        chk("reset_aempty", 32'(ae0), 32'd1);

        // Fill 0x01..0x10, then one rejected write
        for (int i = 1; i <= 16; i++) step(1, 8'(i), 0, 0, 0);
        chk("fill_count", 32'(count0), 32'd16);
        chk("fill_wfull", 32'(wfull0), 32'd1);
        step(1, 8'hAA, 0, 0, 0);
        chk("fill_ovf", 32'(ovf0), 32'd1);
        chk("fill_count_hold", 32'(count0), 32'd16);

        // Drain in order, then one rejected read
        for (int i = 1; i <= 16; i++) begin
            step(0, 8'h00, 1, 0, 0);
            chk("drain_data", 32'(rdata0), 32'(i));
        end
        step(0, 8'h00, 1, 0, 0);
        chk("drain_udf", 32'(udf0), 32'd1);
        chk("drain_hold", 32'(rdata0), 32'h10);
        step(0, 8'h00, 0, 1, 0);

        // Simultaneous read/write at count 5, pointers wrap
        for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 8'($urandom), 1, 0, 0);
        chk("simul_count", 32'(count0), 32'd5);

        // Full plus read: write rejected, read accepted
        for (int i = 0; i < 11; i++) step(1, 8'($urandom), 0, 0, 0);
        step(1, 8'hEE, 1, 0, 0);
        chk("fullrd_count", 32'(count0), 32'd15);
        chk("fullrd_ovf", 32'(ovf0), 32'd1);
        step(0, 8'h00, 0, 1, 0);
        chk("clr_ovf", 32'(ovf0), 32'd0);

        // Reset mid-stream at count 9 with a write pending
        for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 0, 0);
        chk("pre_reset_count", 32'(count0), 32'd9);
        step(1, 8'h77, 0, 0, 1);
        chk("midrst_count", 32'(count0), 32'd0);
        step(0, 8'h00, 0, 0, 0);

        // FWFT head presentation
        step(1, 8'h3C, 0, 0, 0);
        chk("fwft_rvalid", 32'(rvalid1), 32'd1);
        chk("fwft_rdata", 32'(rdata1), 32'h3C);
        step(0, 8'h00, 1, 0, 0);
        chk("fwft_empty", 32'(rempty1), 32'd1);
        chk("fwft_rvalid_off", 32'(rvalid1), 32'd0);

        // Randomized phases alternating fill-biased and drain-biased traffic
        for (int ph = 0; ph < 6; ph++) begin
            wp = (ph % 2 == 0) ? 80 : 20;
            for (int i = 0; i < 100; i++) begin
                w  = ($urandom_range(0, 99) < wp);
                r  = ($urandom_range(0, 99) < (100 - wp));
                c  = ($urandom_range(0, 15) == 0);
                rs = ($urandom_range(0, 299) == 0);
                step(w, 8'($urandom), r, c, rs);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
